pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
// Program-counter and instruction-fetch stage. It holds the fetch PC and selects the next PC:
//   sequential, branch target, jump target (from the jump-address stage) or jump-register target.
// It runs a REQ/ACK handshake with instruction memory.
// Fetched words go to decode through a 2-entry instruction/PC queue.
// Upstream: branch unit, jump-address stage, register file (JR). Downstream: decode/issue.
// PARAMETERS
// RESET_PC  32'h0000_0000  fetch address after reset
// PC_STEP   4              byte increment between sequential fetches
// PORTS
// CLK        in   1   single clock, rising edge
// RST        in   1   synchronous, active-high reset
// STALL      in   1   decode cannot accept the queue head this cycle
// BR_TAKEN   in   1   taken-branch redirect
// BR_TARGET  in   32  branch target address
// JR         in   1   jump-register redirect
// JR_ADDR    in   32  register-sourced target
// JUMP       in   1   J/JAL redirect
// JUMP_ADDR  in   32  target from jump-address stage; used as-is
// IMEM_REQ   out  1   fetch request
// IMEM_ADDR  out  32  fetch address; held stable while IMEM_REQ=1 and IMEM_ACK=0
// IMEM_ACK   in   1   IMEM_DATA valid; completes the request
// IMEM_DATA  in   32  fetched instruction word
// INST       out  32  queue-head instruction
// PC         out  32  address of INST
// PC_PLUS4   out  32  PC + PC_STEP (link value), combinational
// INST_VALID out  1   queue non-empty
// BEHAVIOUR
// - Clocking: one clock (CLK); RST is synchronous, active-high, and overrides everything, including mid-request.
// - Reset values:
//   - State S_RST; FPC = REQ_ADDR = RESET_PC; queue count 0; drop 0.
//   - INST = 0, PC = RESET_PC, INST_VALID = 0, IMEM_REQ = 0.
//   - Memory acknowledges in flight at reset are ignored.
// - REDIR = BR_TAKEN|JR|JUMP. Priority: BR_TAKEN > JR > JUMP (oldest instruction wins).
// - Target is used unmodified: no shift, no alignment; bits[1:0] pass through.
// - POP = INST_VALID & ~STALL & ~REDIR. PUSH = ACK accepted (see S_REQ).
// - FSM:
//   - S_RST: IMEM_REQ=0. Goes to S_REQ next cycle, REQ_ADDR=FPC.
//   - S_IDLE: IMEM_REQ=0. Goes to S_REQ when (count - POP) < 2, loading REQ_ADDR=FPC; else stays.
//   - S_REQ: IMEM_REQ=1, IMEM_ADDR=REQ_ADDR.
//     - On ACK with ~drop & ~REDIR: push {REQ_ADDR, IMEM_DATA}; FPC <= REQ_ADDR + PC_STEP.
//     - After ACK: if space remains after push/pop, stay in S_REQ with REQ_ADDR <= new FPC (back-to-back); else go to S_IDLE.
// - Throughput: one instruction/cycle with zero-wait memory (ACK in the request cycle).
// - Redirect (effective at the edge; overrides STALL):
//   - Queue flushed (count 0, INST_VALID 0 next cycle); FPC <= target.
//   - In S_REQ with no ACK: drop <= 1; IMEM_ADDR is held; the next ACK's data is discarded and clears drop.
//   - Then the request restarts at FPC.
//   - REDIR together with ACK: data discarded, drop stays 0, next request at target.
//   - Repeated redirects while drop=1: the last target wins; only one ACK is discarded.
// - Queue: 2 entries, FIFO order; simultaneous PUSH and POP keeps count.
//   - No push when full: requests issue only when space is guaranteed.
// - Arithmetic: FPC + PC_STEP wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
// - Latency:
//   - RST falls before edge k: IMEM_REQ=1 in cycle k+1.
//   - With ACK in k+1: INST_VALID=1 in k+2, PC=RESET_PC.
// TESTING
// T1 reset/stream: zero-wait ACK, 3 cycles -> PC 0,4,8; INST = mem words; INST_VALID steady 1.
// T2 stall/backpressure: STALL=1 for 4 cycles -> count reaches 2; IMEM_REQ drops; INST/PC held.
//    On release: order preserved, no loss or duplication.
// T3 jump mid-request: ACK delayed 3 cycles, JUMP=1 with JUMP_ADDR=32'h0400_0100 on cycle 1 ->
//    IMEM_ADDR held until ACK, data discarded, next IMEM_ADDR=32'h0400_0100, queue empty meanwhile.
// T4 priority: BR_TAKEN (0x200), JR (0x300), JUMP (0x400) same cycle -> next fetch at 0x200;
//    JR+JUMP -> 0x300.
// T5 wrap/redirect+ACK: FPC=32'hFFFF_FFFC fetched -> next 32'h0;
//    REDIR coincident with ACK -> that word never appears on INST.
// T6 reset mid-operation: RST during S_REQ with queue full -> next cycle INST_VALID=0, IMEM_REQ=0;
//    refetch starts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter / instruction fetch: next-PC select, IMEM REQ/ACK handshake, 2-entry inst/PC queue to decode.
// Latency: one cycle in S_RST after reset, then IMEM_REQ; an ACK in cycle k makes INST_VALID visible in k+1.
// Backpressure: STALL holds the queue head; requests are only issued when a slot is guaranteed, else fetch idles.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {S_RST, S_IDLE, S_REQ} state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] ent_pc_q [2];
    logic [31:0] ent_pc_d [2];
    logic [31:0] ent_inst_q [2];
    logic [31:0] ent_inst_d [2];

    logic        redir;
    logic [31:0] target;
    logic        pop;
    logic        push;
    logic [1:0]  cnt_pop;

    // Next-PC select, queue update and fetch FSM; oldest redirect source wins.
    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        req_addr_d    = req_addr_q;
        drop_d        = drop_q;
        ent_pc_d[0]   = ent_pc_q[0];
        ent_pc_d[1]   = ent_pc_q[1];
        ent_inst_d[0] = ent_inst_q[0];
        ent_inst_d[1] = ent_inst_q[1];

        redir  = br_taken_i | jr_i | jump_i;
        target = br_taken_i ? br_target_i : (jr_i ? jr_addr_i : jump_addr_i);
        pop    = (cnt_q != 2'd0) & ~stall_i & ~redir;
        // Data arriving with a redirect, or owed to an earlier redirect, is wrong-path.
        push   = (state_q == S_REQ) & imem_ack_i & ~drop_q & ~redir;

        // Head-at-index-0 shift queue; a redirect flushes whatever is queued.
        cnt_pop = cnt_q - {1'b0, pop};
        if (pop) begin
            ent_pc_d[0]   = ent_pc_q[1];
            ent_inst_d[0] = ent_inst_q[1];
        end
        if (redir) begin
            cnt_pop = 2'd0;
        end
        if (push) begin
            if (cnt_pop == 2'd0) begin
                ent_pc_d[0]   = req_addr_q;
                ent_inst_d[0] = imem_data_i;
            end else begin
                ent_pc_d[1]   = req_addr_q;
                ent_inst_d[1] = imem_data_i;
            end
        end
        cnt_d = cnt_pop + {1'b0, push};

        if (redir) begin
            fpc_d = target;
        end else if (push) begin
            fpc_d = req_addr_q + PC_STEP;
        end

        case (state_q)
            S_RST: begin
                state_d    = S_REQ;
                req_addr_d = fpc_d;
            end
            S_IDLE: begin
                if (cnt_d < 2'd2) begin
                    state_d    = S_REQ;
                    req_addr_d = fpc_d;
                end
            end
            S_REQ: begin
                if (imem_ack_i) begin
                    drop_d = 1'b0;
                    if (cnt_d < 2'd2) begin
                        req_addr_d = fpc_d;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (redir) begin
                    // Address stays on the bus; the response is owed and must be thrown away.
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    // State registers with synchronous reset that overrides any request in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_RST;
            fpc_q         <= RESET_PC;
            req_addr_q    <= RESET_PC;
            drop_q        <= 1'b0;
            cnt_q         <= 2'd0;
            ent_pc_q[0]   <= RESET_PC;
            ent_pc_q[1]   <= RESET_PC;
            ent_inst_q[0] <= 32'h0;
            ent_inst_q[1] <= 32'h0;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            req_addr_q    <= req_addr_d;
            drop_q        <= drop_d;
            cnt_q         <= cnt_d;
            ent_pc_q[0]   <= ent_pc_d[0];
            ent_pc_q[1]   <= ent_pc_d[1];
            ent_inst_q[0] <= ent_inst_d[0];
            ent_inst_q[1] <= ent_inst_d[1];
        end
    end

    assign imem_req_o   = (state_q == S_REQ);
    assign imem_addr_o  = req_addr_q;
    assign inst_o       = ent_inst_q[0];
    assign pc_o         = ent_pc_q[0];
    assign pc_plus4_o   = ent_pc_q[0] + PC_STEP;
    assign inst_valid_o = (cnt_q != 2'd0);

endmodule
